// File: rtl/video_timing_monitor.sv
// rtl/video_timing_monitor.sv - video_if receiver: line/frame geometry, lock FSM, timing error count
// Optional frame signature built only when VIDMON_CRC_EN is defined.
module video_timing_monitor #(
    parameter int HDISP       = 800,
    parameter int VDISP       = 480,
    parameter int CW          = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst_n,
    input  logic          VGA_HS,
    input  logic          VGA_VS,
    input  logic          VGA_BLANK,
    input  logic [7:0]    VGA_R,
    input  logic [7:0]    VGA_G,
    input  logic [7:0]    VGA_B,
    output logic          locked,
    output logic [CW-1:0] h_act,
    output logic [CW-1:0] h_tot,
    output logic [CW-1:0] v_act,
    output logic [CW-1:0] v_tot,
    output logic [15:0]   err_count,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   frame_crc
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] CMAX    = '1;
    localparam logic [CW-1:0] HDISP_C = CW'(HDISP);
    localparam logic [CW-1:0] VDISP_C = CW'(VDISP);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

    logic          r_hs, r_hs_d, r_vs, r_vs_d, r_blank;
    logic [CW-1:0] r_pix_cnt, r_clk_cnt, r_lines, r_act_lines;
    logic          r_bad_line;
    state_t        r_state;
    logic [GW-1:0] r_good_cnt;

    logic          w_hs_fall, w_vs_fall, w_timeout, w_good;
    logic          w_line_active, w_line_bad;
    logic [CW-1:0] w_lines, w_act_lines, w_h_act;
    logic          w_bad;
    logic [GW-1:0] w_good_next;

    assign w_hs_fall     = r_hs_d & ~r_hs;
    assign w_vs_fall     = r_vs_d & ~r_vs;
    assign w_line_active = (r_pix_cnt != '0);
    assign w_line_bad    = w_line_active && (r_pix_cnt != HDISP_C);

    // Frame-end view including a line closed by an HS fall in this same cycle
    assign w_lines     = (w_hs_fall && r_lines != CMAX) ? r_lines + CW'(1) : r_lines;
    assign w_act_lines = (w_hs_fall && w_line_active && r_act_lines != CMAX)
                         ? r_act_lines + CW'(1) : r_act_lines;
    assign w_bad       = r_bad_line | (w_hs_fall & w_line_bad);
    assign w_h_act     = w_hs_fall ? r_pix_cnt : h_act;
    assign w_good      = (w_act_lines == VDISP_C) && !w_bad && (w_h_act == HDISP_C);
    assign w_timeout   = !w_hs_fall && (r_clk_cnt == CMAX);
    assign w_good_next = r_good_cnt + GW'(1);

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_hs        <= 1'b0;
            r_hs_d      <= 1'b0;
            r_vs        <= 1'b0;
            r_vs_d      <= 1'b0;
            r_blank     <= 1'b0;
            r_pix_cnt   <= '0;
            r_clk_cnt   <= '0;
            r_lines     <= '0;
            r_act_lines <= '0;
            r_bad_line  <= 1'b0;
            h_act       <= '0;
            h_tot       <= '0;
            v_act       <= '0;
            v_tot       <= '0;
            frame_cnt   <= '0;
        end else begin
            r_hs    <= VGA_HS;
            r_hs_d  <= r_hs;
            r_vs    <= VGA_VS;
            r_vs_d  <= r_vs;
            r_blank <= VGA_BLANK;
            if (w_hs_fall) begin
                h_act     <= r_pix_cnt;
                h_tot     <= r_clk_cnt;
                r_pix_cnt <= '0;
                r_clk_cnt <= CW'(1);
            end else begin
                if (r_blank && r_pix_cnt != CMAX)
                    r_pix_cnt <= r_pix_cnt + CW'(1);
                if (r_clk_cnt != CMAX)
                    r_clk_cnt <= r_clk_cnt + CW'(1);
            end
            if (w_vs_fall) begin
                v_act       <= w_act_lines;
                v_tot       <= w_lines;
                frame_cnt   <= frame_cnt + 16'd1;
                r_lines     <= '0;
                r_act_lines <= '0;
                r_bad_line  <= 1'b0;
            end else begin
                r_lines     <= w_lines;
                r_act_lines <= w_act_lines;
                r_bad_line  <= w_bad;
            end
        end
    end

    // A lost HS overrides any frame decision taken in the same cycle
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= '0;
            locked     <= 1'b0;
            err_count  <= '0;
        end else if (w_timeout) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= '0;
            locked     <= 1'b0;
        end else if (w_vs_fall) begin
            case (r_state)
                ST_SEARCH: begin
                    r_state    <= ST_MEASURE;
                    r_good_cnt <= '0;
                end
                ST_MEASURE: begin
                    if (w_good) begin
                        r_good_cnt <= w_good_next;
                        if (w_good_next == GW'(LOCK_FRAMES)) begin
                            r_state <= ST_LOCKED;
                            locked  <= 1'b1;
                        end
                    end else begin
                        r_good_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_good) begin
                        if (err_count != 16'hFFFF)
                            err_count <= err_count + 16'd1;
                        locked     <= 1'b0;
                        r_good_cnt <= '0;
                        r_state    <= ST_MEASURE;
                    end
                end
                default: r_state <= ST_SEARCH;
            endcase
        end
    end

`ifdef VIDMON_CRC_EN
    logic [7:0]  r_red, r_grn, r_blu;
    logic [15:0] r_crc;

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_red     <= '0;
            r_grn     <= '0;
            r_blu     <= '0;
            r_crc     <= 16'hFFFF;
            frame_crc <= '0;
        end else begin
            r_red <= VGA_R;
            r_grn <= VGA_G;
            r_blu <= VGA_B;
            if (w_vs_fall) begin
                frame_crc <= r_crc;
                r_crc     <= 16'hFFFF;
            end else if (r_blank) begin
                r_crc <= {r_crc[14:0], r_crc[15]} ^ {r_red ^ r_grn, r_blu};
            end
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^{VGA_R, VGA_G, VGA_B};
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_video_timing_monitor.sv
// tb/tb_video_timing_monitor.sv - randomized frames against an event-level model of the monitor
module tb_video_timing_monitor;

    localparam int HDISP = 20, VDISP = 6, CW = 12, LOCK_FRAMES = 2;
    localparam int HTOT = 32, VTOT = 10, HS_W = 4, HBP = 8, VACT0 = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hs = 1'b1, vs = 1'b1, blank = 1'b0;
    logic [7:0]    r = '0, g = '0, b = '0;
    logic          locked;
    logic [CW-1:0] h_act, h_tot, v_act, v_tot;
    logic [15:0]   err_count, frame_cnt, frame_crc;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    video_timing_monitor #(.HDISP(HDISP), .VDISP(VDISP), .CW(CW), .LOCK_FRAMES(LOCK_FRAMES)) dut (
        .pixel_clk(clk), .pixel_rst_n(rst_n),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK(blank),
        .VGA_R(r), .VGA_G(g), .VGA_B(b),
        .locked(locked), .h_act(h_act), .h_tot(h_tot), .v_act(v_act), .v_tot(v_tot),
        .err_count(err_count), .frame_cnt(frame_cnt), .frame_crc(frame_crc)
    );

    // Model: wire samples seen two edges late, lines kept as a queue of pixel counts per frame
    int          q_hs[2], q_vs[2];
    int          p_bl;
    logic [15:0] p_px;
    int          since_hs, line_pix, m_mode, m_run;
    int          lines[$];
    logic [15:0] m_crc;
    logic          m_locked;
    logic [CW-1:0] m_h_act, m_h_tot, m_v_act, m_v_tot;
    logic [15:0]   m_err, m_frames, m_fcrc;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic m_reset();
        q_hs = '{0, 0}; q_vs = '{0, 0}; p_bl = 0; p_px = '0;
        since_hs = 0; line_pix = 0; m_mode = 0; m_run = 0;
        lines.delete();
        m_crc = 16'hFFFF; m_fcrc = '0;
        m_locked = 1'b0; m_h_act = '0; m_h_tot = '0; m_v_act = '0; m_v_tot = '0;
        m_err = '0; m_frames = '0;
    endtask

    task automatic m_step();
        bit hs_fall, vs_fall, timeout, good, bad;
        int act;
        hs_fall = (q_hs[1] != 0) && (q_hs[0] == 0);
        vs_fall = (q_vs[1] != 0) && (q_vs[0] == 0);
        timeout = !hs_fall && (since_hs >= CMAX);
        if (hs_fall) begin
            m_h_act = CW'(sat(line_pix));
            m_h_tot = CW'(sat(since_hs));
            lines.push_back(sat(line_pix));
            line_pix = 0;
            since_hs = 1;
        end else begin
            since_hs++;
            if (p_bl != 0) line_pix++;
        end
`ifdef VIDMON_CRC_EN
        if (vs_fall) begin
            m_fcrc = m_crc;
            m_crc  = 16'hFFFF;
        end else if (p_bl != 0) begin
            m_crc = {m_crc[14:0], m_crc[15]} ^ p_px;
        end
`endif
        good = 1'b0;
        if (vs_fall) begin
            act = 0; bad = 1'b0;
            foreach (lines[i]) if (lines[i] != 0) begin
                act++;
                if (lines[i] != HDISP) bad = 1'b1;
            end
            m_v_act  = CW'(sat(act));
            m_v_tot  = CW'(sat(lines.size()));
            m_frames = m_frames + 16'd1;
            good     = (act == VDISP) && !bad && (m_h_act == CW'(HDISP));
            lines.delete();
        end
        if (timeout) begin
            m_mode = 0; m_run = 0; m_locked = 1'b0;
        end else if (vs_fall) begin
            if (m_mode == 0) begin
                m_mode = 1; m_run = 0;
            end else if (m_mode == 1) begin
                if (good) begin
                    m_run++;
                    if (m_run == LOCK_FRAMES) begin m_mode = 2; m_locked = 1'b1; end
                end else m_run = 0;
            end else if (!good) begin
                if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                m_locked = 1'b0; m_run = 0; m_mode = 1;
            end
        end
        q_hs[1] = q_hs[0]; q_hs[0] = int'(hs);
        q_vs[1] = q_vs[0]; q_vs[0] = int'(vs);
        p_bl = int'(blank);
        p_px = {r ^ g, b};
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    always @(negedge clk) begin
        checks++;
        if (locked !== m_locked || h_act !== m_h_act || h_tot !== m_h_tot || v_act !== m_v_act ||
            v_tot !== m_v_tot || err_count !== m_err || frame_cnt !== m_frames || frame_crc !== m_fcrc) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t dut lk=%0d ha=%0d ht=%0d va=%0d vt=%0d err=%0d fc=%0d crc=%h model lk=%0d ha=%0d ht=%0d va=%0d vt=%0d err=%0d fc=%0d crc=%h",
                     $time, locked, h_act, h_tot, v_act, v_tot, err_count, frame_cnt, frame_crc,
                     m_locked, m_h_act, m_h_tot, m_v_act, m_v_tot, m_err, m_frames, m_fcrc);
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input bit h, input bit v, input bit bl, input bit zero);
        @(negedge clk);
        hs = h; vs = v; blank = bl;
        r = zero ? 8'h00 : 8'($urandom);
        g = zero ? 8'h00 : 8'($urandom);
        b = zero ? 8'h00 : 8'($urandom);
    endtask

    // Active lines sit at the end of the frame; VS falls within line 0 at vs_off
    task automatic drive_frame(input int start_line, input int short_line, input int vs_off, input bit zero);
        for (int y = start_line; y < VTOT; y++) begin
            for (int x = 0; x < HTOT; x++) begin
                int pos, aend;
                pos  = y * HTOT + x;
                aend = (y == short_line) ? HBP + HDISP - 1 : HBP + HDISP;
                tick(x >= HS_W, !(pos >= vs_off && pos < vs_off + 2 * HTOT),
                     (y >= VACT0) && (x >= HBP) && (x < aend), zero);
            end
        end
        #1;
    endtask

    task automatic good_frame();
        drive_frame(0, -1, $urandom_range(0, 20), 1'b0);
    endtask

    task automatic check_zero(input string tag);
        lit({tag, "_locked"}, int'(locked), 0);
        lit({tag, "_h_act"}, int'(h_act), 0);
        lit({tag, "_h_tot"}, int'(h_tot), 0);
        lit({tag, "_v_act"}, int'(v_act), 0);
        lit({tag, "_v_tot"}, int'(v_tot), 0);
        lit({tag, "_err"}, int'(err_count), 0);
        lit({tag, "_frames"}, int'(frame_cnt), 0);
        lit({tag, "_crc"}, int'(frame_crc), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // T1: partial frame ignored, lock after the third VS fall
        drive_frame(5, -1, 0, 1'b0);
        good_frame(); good_frame();
        lit("t1_frames2", int'(frame_cnt), 2);
        lit("t1_unlocked", int'(locked), 0);
        good_frame();
        lit("t1_locked", int'(locked), 1);
        lit("t1_h_act", int'(h_act), HDISP);
        lit("t1_h_tot", int'(h_tot), HTOT);
        lit("t1_v_act", int'(v_act), VDISP);
        lit("t1_v_tot", int'(v_tot), VTOT);
        lit("t1_err", int'(err_count), 0);

        // T5: HS and VS falling on the same cycle
        drive_frame(0, -1, 0, 1'b0);
        drive_frame(0, -1, 0, 1'b0);
        lit("t5_locked", int'(locked), 1);
        lit("t5_v_tot", int'(v_tot), VTOT);
        lit("t5_v_act", int'(v_act), VDISP);

        // T2: one short line while locked
        drive_frame(0, 6, $urandom_range(0, 20), 1'b0);
        good_frame();
        lit("t2_unlocked", int'(locked), 0);
        lit("t2_err", int'(err_count), 1);
        good_frame();
        lit("t2_still_unlocked", int'(locked), 0);
        good_frame();
        lit("t2_relocked", int'(locked), 1);

        // T6: all-zero pixels leave the signature at its seed value
        drive_frame(0, -1, 3, 1'b1);
        drive_frame(0, -1, 0, 1'b1);
`ifdef VIDMON_CRC_EN
        lit("t6_crc_a", int'(frame_crc), 16'hFFFF);
`else
        lit("t6_crc_a", int'(frame_crc), 0);
`endif
        drive_frame(0, -1, 5, 1'b0);
`ifdef VIDMON_CRC_EN
        lit("t6_crc_b", int'(frame_crc), 16'hFFFF);
`else
        lit("t6_crc_b", int'(frame_crc), 0);
`endif

        // T3: sync loss
        for (int i = 0; i < 4096; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        lit("t3_unlocked", int'(locked), 0);
        lit("t3_err", int'(err_count), 1);
        good_frame(); good_frame();
        lit("t3_search_unlocked", int'(locked), 0);
        good_frame();
        lit("t3_relocked", int'(locked), 1);

        // T4: asynchronous reset mid-line, released mid-frame
        fork
            drive_frame(0, -1, 7, 1'b0);
            begin
                repeat (100) @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check_zero("t4");
                repeat (40) @(negedge clk);
                #2 rst_n = 1'b1;
            end
        join
        good_frame(); good_frame();
        lit("t4_frames2", int'(frame_cnt), 2);
        lit("t4_unlocked", int'(locked), 0);
        good_frame();
        lit("t4_locked", int'(locked), 1);

        // Randomized geometry disturbances, checked by the model every cycle
        for (int f = 0; f < 10; f++) begin
            drive_frame(0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(VACT0, VTOT - 1)) : -1,
                        $urandom_range(0, 20), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
